// File: rtl/onewire_pkg.sv
// Shared definitions for the 1-Wire responder.
// Holds the FSM state type and the slot/reset/presence timing, expressed in
// prescaler ticks (standard or overdrive tick length, chosen by the top).
package onewire_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SLOT,
    ST_RST_LOW,
    ST_PRS_WAIT,
    ST_PRS_DRIVE,
    ST_PRS_END
  } state_t;

  localparam int unsigned TW = 6;

  localparam logic [TW-1:0] T_SMP = 6'd4;   // sample / stop driving tx bit
  localparam logic [TW-1:0] T_RST = 6'd48;  // low this long means bus reset
  localparam logic [TW-1:0] T_PRW = 6'd4;   // wait before presence pulse
  localparam logic [TW-1:0] T_PRD = 6'd16;  // presence pulse length
  localparam logic [TW-1:0] T_SAT = 6'd63;  // tick counter saturation

  function automatic logic [TW-1:0] tick_inc(input logic [TW-1:0] t);
    return (t == T_SAT) ? t : t + 6'd1;
  endfunction

endpackage

// File: rtl/onewire_responder_if.sv
// Byte-level handshake between the 1-Wire responder and its local host.
//   rx_valid : one-cycle pulse, rx_data holds the received byte
//   rx_data  : last received byte (held until the next one completes)
//   tx_valid : host offers tx_data for the next 8 bus slots
//   tx_data  : byte to send, LSB first
//   tx_ready : responder accepts tx_data when tx_valid & tx_ready
// Modports: slave = responder side, master = host side.
interface onewire_responder_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport slave (
    output rx_valid, rx_data, tx_ready,
    input  tx_valid, tx_data
  );

  modport master (
    input  rx_valid, rx_data, tx_ready,
    output tx_valid, tx_data
  );
endinterface

// File: rtl/onewire_responder_tick.sv
// Timing prescaler for the 1-Wire responder.
//   clk     : system clock
//   rst     : asynchronous active-low reset
//   restart : clears the count; no tick is issued in that cycle
//   period  : clk cycles per tick
//   count   : current prescaler count
//   tick    : one-cycle pulse every 'period' cycles after a restart
module onewire_responder_tick #(
  parameter int unsigned CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          restart,
  input  logic [CW-1:0] period,
  output logic [CW-1:0] count,
  output logic          tick
);

  // >= keeps the counter bounded if the period shrinks mid-count
  assign tick = !restart && (count >= period - CW'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (restart || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/onewire_responder.sv
// 1-Wire slave (responder): byte receive/transmit, bus reset detection and
// presence pulse generation on an open-drain line.
//   clk      : system clock
//   rst      : asynchronous active-low reset
//   onewire  : open-drain bus, driven 0 or z only (external pullup)
//   ovd      : overdrive timing select (only with ONEWIRE_RESPONDER_OVD_EN)
//   rst_det  : one-cycle pulse on detected bus reset
//   app      : byte handshake to the local host (onewire_responder_if.slave)
// Parameters: DVN = clk cycles per standard tick, ODN = clk cycles per
// overdrive tick.
// Build option: ONEWIRE_RESPONDER_OVD_EN adds the ovd port and ODN timing.
module onewire_responder
  import onewire_pkg::*;
#(
  parameter int unsigned DVN = 30,
  parameter int unsigned ODN = 4
) (
  input  logic clk,
  input  logic rst,
  inout  wire  onewire,
`ifdef ONEWIRE_RESPONDER_OVD_EN
  input  logic ovd,
`endif
  output logic rst_det,
  onewire_responder_if.slave app
);

  localparam int unsigned PMAX = (DVN > ODN) ? DVN : ODN;
  localparam int unsigned CW   = $clog2(PMAX + 1);

  state_t        state;
  logic [TW-1:0] tcnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    rx_sh;
  logic [7:0]    tx_byte;
  logic          tx_active;
  logic          byte_done;
  logic          drive_low;
  logic          enter_q;
  logic          rx_valid_q;
  logic [7:0]    rx_data_q;

  logic          sync1, sync2, line_q;
  logic          line, fall;
  logic          restart, tick;
  logic [CW-1:0] period;
  logic [CW-1:0] pre_cnt_unused;

  logic          tx_ready_int, tx_take, cur_active;
  logic [7:0]    cur_byte;
  logic          in_presence;

  assign onewire = drive_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      line_q <= 1'b1;
    end else begin
      sync1  <= onewire;
      sync2  <= sync1;
      line_q <= sync2;
    end
  end

  assign line = sync2;
  assign fall = line_q & ~sync2;

`ifdef ONEWIRE_RESPONDER_OVD_EN
  logic ovd_q;
  // Timing mode only switches between transactions
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  ovd_q <= 1'b0;
    else if (state == ST_IDLE) ovd_q <= ovd;
  end
  assign period = ovd_q ? CW'(ODN) : CW'(DVN);
`else
  assign period = CW'(DVN);
`endif

  // Our own presence pulse creates a falling edge; it must not disturb
  // the presence timing, so edges in the presence states are not restarts.
  assign in_presence = (state == ST_PRS_WAIT) || (state == ST_PRS_DRIVE) ||
                       (state == ST_PRS_END);
  assign restart     = enter_q | (fall & ~in_presence);

  onewire_responder_tick #(.CW(CW)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .period  (period),
    .count   (pre_cnt_unused),
    .tick    (tick)
  );

  assign tx_ready_int = (state == ST_IDLE) && (bit_cnt == 3'd0) && !tx_active;
  assign tx_take      = tx_ready_int && app.tx_valid;
  // A byte accepted in the same cycle as a falling edge drives that slot
  assign cur_byte     = tx_take ? app.tx_data : tx_byte;
  assign cur_active   = tx_take | tx_active;

  assign app.tx_ready = tx_ready_int;
  assign app.rx_valid = rx_valid_q;
  assign app.rx_data  = rx_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      tcnt       <= '0;
      bit_cnt    <= '0;
      rx_sh      <= '0;
      tx_byte    <= '0;
      tx_active  <= 1'b0;
      byte_done  <= 1'b0;
      drive_low  <= 1'b0;
      enter_q    <= 1'b0;
      rst_det    <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      rst_det    <= 1'b0;
      rx_valid_q <= 1'b0;
      enter_q    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_take) begin
            tx_byte   <= app.tx_data;
            tx_active <= 1'b1;
          end
          if (fall) begin
            state     <= ST_SLOT;
            tcnt      <= '0;
            drive_low <= cur_active & ~cur_byte[bit_cnt];
          end
        end
        ST_SLOT: begin
          if (tick) tcnt <= tick_inc(tcnt);
          if (tick && (tcnt == T_SMP - 6'd1)) begin
            rx_sh[bit_cnt] <= line;
            bit_cnt        <= bit_cnt + 3'd1;
            byte_done      <= (bit_cnt == 3'd7);
            drive_low      <= 1'b0;
          end
          // End of slot is only meaningful once the sample point has passed
          if ((tcnt >= T_SMP) && line) begin
            state   <= ST_IDLE;
            enter_q <= 1'b1;
            if (byte_done) begin
              rx_valid_q <= 1'b1;
              rx_data_q  <= rx_sh;
              tx_active  <= 1'b0;
              byte_done  <= 1'b0;
            end
          end else if (tick && (tcnt == T_RST - 6'd1)) begin
            rst_det   <= 1'b1;
            bit_cnt   <= '0;
            tx_active <= 1'b0;
            byte_done <= 1'b0;
            tcnt      <= '0;
            state     <= ST_RST_LOW;
            enter_q   <= 1'b1;
          end
        end
        ST_RST_LOW: begin
          if (line) begin
            state   <= ST_PRS_WAIT;
            tcnt    <= '0;
            enter_q <= 1'b1;
          end
        end
        ST_PRS_WAIT: begin
          if (tick) begin
            tcnt <= tick_inc(tcnt);
            if (tick_inc(tcnt) == T_PRW) begin
              state     <= ST_PRS_DRIVE;
              tcnt      <= '0;
              enter_q   <= 1'b1;
              drive_low <= 1'b1;
            end
          end
        end
        ST_PRS_DRIVE: begin
          if (tick) begin
            tcnt <= tick_inc(tcnt);
            if (tick_inc(tcnt) == T_PRD) begin
              state     <= ST_PRS_END;
              tcnt      <= '0;
              enter_q   <= 1'b1;
              drive_low <= 1'b0;
            end
          end
        end
        ST_PRS_END: begin
          if (line) begin
            state   <= ST_IDLE;
            enter_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_onewire_responder.sv
`timescale 1ns/1ps
module tb_onewire_responder;

  localparam int DVN = 30;
  localparam int ODN = 4;

  // Bus timing in clk cycles (4 MHz => 250 ns per cycle)
  localparam int STD_RST_HOLD = 1920; // 480 us
  localparam int STD_LOW1     = 24;   // 6 us
  localparam int STD_LOW0     = 240;  // 60 us
  localparam int STD_SLOT     = 260;  // 65 us
  localparam int STD_REC      = 20;   // 5 us
  localparam int RD_LOW       = 4;    // 1 us
  localparam int RD_SMP       = 60;   // 15 us

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic m_low = 1'b0;
  wire  ow;
  logic rst_det;

  pullup (ow);
  assign ow = m_low ? 1'b0 : 1'bz;

`ifdef ONEWIRE_RESPONDER_OVD_EN
  logic ovd = 1'b0;
`endif

  onewire_responder_if app();

  onewire_responder #(.DVN(DVN), .ODN(ODN)) dut (
    .clk     (clk),
    .rst     (rst),
    .onewire (ow),
`ifdef ONEWIRE_RESPONDER_OVD_EN
    .ovd     (ovd),
`endif
    .rst_det (rst_det),
    .app     (app)
  );

  always #125 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int         rxv_cnt = 0;
  logic [7:0] rxv_last = 8'h00;

  always @(negedge clk) begin
    if (app.rx_valid === 1'b1) begin
      rxv_cnt++;
      rxv_last = app.rx_data;
    end
  end

  task automatic write_slot(input logic b, input int low1, input int low0,
                            input int slot, input int rec);
    @(negedge clk);
    m_low = 1'b1;
    repeat (b ? low1 : low0) @(negedge clk);
    m_low = 1'b0;
    repeat (slot - (b ? low1 : low0)) @(negedge clk);
    repeat (rec) @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] b, input int low1, input int low0,
                            input int slot, input int rec);
    for (int i = 0; i < 8; i++) write_slot(b[i], low1, low0, slot, rec);
  endtask

  // Master read slot; optionally offers a tx byte in the cycle the responder
  // sees the synchronized falling edge.
  task automatic read_slot(output logic bit_o, input logic offer, input logic [7:0] ob);
    bit_o = 1'bx;
    @(negedge clk);
    m_low = 1'b1;
    for (int k = 1; k <= STD_SLOT; k++) begin
      @(negedge clk);
      if (offer && k == 2) begin
        app.tx_valid = 1'b1;
        app.tx_data  = ob;
      end
      if (offer && k == 3) app.tx_valid = 1'b0;
      if (k == RD_LOW) m_low = 1'b0;
      if (k == RD_SMP) bit_o = ow;
    end
    repeat (STD_REC) @(negedge clk);
  endtask

  // Bus reset + presence, checked against tick-based expectations for tick
  // length t (clk cycles).
  task automatic bus_reset_checked(input string tag, input int hold, input int t);
    int det_at  = -1;
    int det_n   = 0;
    int prs_at  = -1;
    int prs_len = 0;
    int rx0     = rxv_cnt;
    @(negedge clk);
    m_low = 1'b1;
    for (int k = 1; k <= hold; k++) begin
      @(negedge clk);
      if (rst_det === 1'b1) begin
        det_n++;
        if (det_at < 0) det_at = k;
      end
    end
    m_low = 1'b0;
    for (int k = 1; k <= 4 * t + 40; k++) begin
      @(negedge clk);
      if (rst_det === 1'b1) det_n++;
      if (ow === 1'b0) begin
        prs_at = k;
        break;
      end
    end
    if (prs_at >= 0) begin
      prs_len = 1;
      for (int k = 0; k < 16 * t + 40; k++) begin
        @(negedge clk);
        if (ow !== 1'b0) break;
        prs_len++;
      end
    end
    repeat (20) @(negedge clk);

    checks++;
    if (det_n !== 1) begin
      errors++;
      $display("FAIL %s rst_det_count: got %0d expected 1", tag, det_n);
    end
    checks++;
    if (det_at < 48 * t || det_at > 48 * t + 6) begin
      errors++;
      $display("FAIL %s rst_det_time: got %0d cycles expected %0d..%0d", tag, det_at, 48 * t, 48 * t + 6);
    end
    checks++;
    if (prs_at < 4 * t || prs_at > 4 * t + 6) begin
      errors++;
      $display("FAIL %s presence_start: got %0d cycles expected %0d..%0d", tag, prs_at, 4 * t, 4 * t + 6);
    end
    checks++;
    if (prs_len < 16 * t || prs_len > 16 * t + 6) begin
      errors++;
      $display("FAIL %s presence_len: got %0d cycles expected %0d..%0d", tag, prs_len, 16 * t, 16 * t + 6);
    end
    checks++;
    if (rxv_cnt !== rx0) begin
      errors++;
      $display("FAIL %s no_rx_valid: got %0d pulses expected 0", tag, rxv_cnt - rx0);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (rst_det !== 1'b0) begin errors++; $display("FAIL reset_rst_det: got %b expected 0", rst_det); end
    checks++;
    if (app.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", app.rx_valid); end
    checks++;
    if (app.rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", app.rx_data); end
    checks++;
    if (app.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b expected 1", app.tx_ready); end
    checks++;
    if (ow !== 1'b1) begin errors++; $display("FAIL reset_bus_released: got %b expected 1", ow); end
    rst = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (app.tx_ready !== 1'b1 || ow !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_idle: got ready=%b bus=%b expected ready=1 bus=1", app.tx_ready, ow);
    end
  endtask

  task automatic test_bus_reset;
    bus_reset_checked("std_bus_reset", STD_RST_HOLD, DVN);
  endtask

  task automatic test_write(input logic [7:0] b);
    int rx0 = rxv_cnt;
    for (int i = 0; i < 7; i++) write_slot(b[i], STD_LOW1, STD_LOW0, STD_SLOT, STD_REC);
    checks++;
    if (rxv_cnt !== rx0) begin
      errors++;
      $display("FAIL write_early_rx_valid: got %0d pulses after 7 slots expected 0", rxv_cnt - rx0);
    end
    write_slot(b[7], STD_LOW1, STD_LOW0, STD_SLOT, STD_REC);
    checks++;
    if (rxv_cnt !== rx0 + 1) begin
      errors++;
      $display("FAIL write_rx_valid_count: got %0d expected 1", rxv_cnt - rx0);
    end
    checks++;
    if (app.rx_data !== b) begin
      errors++;
      $display("FAIL write_rx_data: got %h expected %h", app.rx_data, b);
    end
  endtask

  // Responder transmits b; simul selects handshake in the same cycle as the
  // first slot's falling edge.
  task automatic test_read(input logic [7:0] b, input logic simul);
    logic bit_o;
    int   rx0 = rxv_cnt;
    checks++;
    if (app.tx_ready !== 1'b1) begin errors++; $display("FAIL read_ready_before: got %b expected 1", app.tx_ready); end
    if (!simul) begin
      @(negedge clk);
      app.tx_valid = 1'b1;
      app.tx_data  = b;
      @(negedge clk);
      app.tx_valid = 1'b0;
      checks++;
      if (app.tx_ready !== 1'b0) begin errors++; $display("FAIL read_ready_after_accept: got %b expected 0", app.tx_ready); end
    end
    for (int i = 0; i < 8; i++) begin
      read_slot(bit_o, simul && (i == 0), b);
      checks++;
      if (bit_o !== b[i]) begin
        errors++;
        $display("FAIL read_bit%0d (simul=%0d): got %b expected %b", i, simul, bit_o, b[i]);
      end
      if (i == 6) begin
        checks++;
        if (app.tx_ready !== 1'b0) begin errors++; $display("FAIL read_ready_slot7: got %b expected 0", app.tx_ready); end
      end
    end
    checks++;
    if (app.tx_ready !== 1'b1) begin errors++; $display("FAIL read_ready_after_byte: got %b expected 1", app.tx_ready); end
    checks++;
    if (rxv_cnt !== rx0 + 1 || rxv_last !== b) begin
      errors++;
      $display("FAIL read_rx_echo: got %0d pulses data %h expected 1 pulse data %h", rxv_cnt - rx0, rxv_last, b);
    end
  endtask

  task automatic test_reset_mid_byte;
    logic [7:0] partial = 8'($urandom);
    logic [7:0] txb     = 8'($urandom) & 8'hFE;
    logic       bit_o;
    for (int i = 0; i < 3; i++) write_slot(partial[i], STD_LOW1, STD_LOW0, STD_SLOT, STD_REC);
    bus_reset_checked("mid_write_reset", STD_RST_HOLD, DVN);
    checks++;
    if (app.tx_ready !== 1'b1) begin errors++; $display("FAIL mid_write_ready: got %b expected 1", app.tx_ready); end
    test_write(8'($urandom));

    // A tx byte cut short by a bus reset must be dropped
    @(negedge clk);
    app.tx_valid = 1'b1;
    app.tx_data  = txb;
    @(negedge clk);
    app.tx_valid = 1'b0;
    for (int i = 0; i < 3; i++) read_slot(bit_o, 1'b0, 8'h00);
    bus_reset_checked("mid_read_reset", STD_RST_HOLD, DVN);
    checks++;
    if (app.tx_ready !== 1'b1) begin errors++; $display("FAIL mid_read_ready: got %b expected 1", app.tx_ready); end
    test_write(8'($urandom));
  endtask

`ifdef ONEWIRE_RESPONDER_OVD_EN
  task automatic test_overdrive;
    int rx0;
    ovd = 1'b1;
    repeat (10) @(negedge clk);
    bus_reset_checked("ovd_bus_reset", 240, ODN);
    rx0 = rxv_cnt;
    write_byte(8'h81, 4, 32, 40, 12);
    checks++;
    if (rxv_cnt !== rx0 + 1 || app.rx_data !== 8'h81) begin
      errors++;
      $display("FAIL ovd_write: got %0d pulses data %h expected 1 pulse data 81", rxv_cnt - rx0, app.rx_data);
    end
    ovd = 1'b0;
    repeat (10) @(negedge clk);
  endtask
`endif

  initial begin
    app.tx_valid = 1'b0;
    app.tx_data  = 8'h00;
    test_reset();
    test_bus_reset();
    test_write(8'hA5);
    for (int n = 0; n < 3; n++) test_write(8'($urandom));
    test_read(8'h3C, 1'b0);
    test_read(8'($urandom), 1'b0);
    test_read(8'($urandom) & 8'hFE, 1'b1);
    test_reset_mid_byte();
`ifdef ONEWIRE_RESPONDER_OVD_EN
    test_overdrive();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
